conv_layer_sequencer: RTL

- Top-level control FSM for one 3x3 convolution layer.
- For every (output channel, input channel) pair it requests a kernel load from the kernel constructor (commence/finished handshake).
- It then streams all valid window positions to the line-buffer/MAC datapath, flagging the first/last input channel so the accumulator clears and writes back correctly.
- Sits between the layer-level start/done control and the kernel constructor + conv datapath.

---
 rtl/cnn_pkg.sv | 26 ++
 rtl/window_pos_counter.sv | 46 ++++
 rtl/conv_layer_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types and geometry helpers for the convolution layer control path.
package cnn_pkg;

    // Convolution kernel edge length (square kernel).
    localparam int K_DIM = 3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_REQ  = 3'd1,
        S_LOAD_WAIT = 3'd2,
        S_STREAM    = 3'd3,
        S_NEXT      = 3'd4,
        S_DONE      = 3'd5
    } seq_state_t;

    // Number of valid window columns for a 'valid' (no padding) convolution.
    function automatic int out_w(input int img_w);
        return img_w - K_DIM + 1;
    endfunction

    // Number of valid window rows for a 'valid' (no padding) convolution.
    function automatic int out_h(input int img_h);
        return img_h - K_DIM + 1;
    endfunction

endpackage

// File: rtl/window_pos_counter.sv
// Raster-order window position counter: walks (row, col) over an
// OUT_H x OUT_W grid, one step per advance, wrapping back to (0,0)
// after the last position.
module window_pos_counter
    import cnn_pkg::*;
#(
    parameter int OUT_W = 26,
    parameter int OUT_H = 26,
    parameter int ROW_W = 5,
    parameter int COL_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             advance,
    input  logic             clear,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    logic col_end;
    logic row_end;

    assign col_end = (col == COL_W'(OUT_W - 1));
    assign row_end = (row == ROW_W'(OUT_H - 1));
    assign last    = col_end & row_end;

    // Position register: clear wins over advance; the final position wraps to origin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Layer-level sequencer for one 3x3 convolution: for each (oc, ic) pair it
// requests a kernel load, waits for it, then streams every valid window
// position to the datapath with accumulator first/last flags.
module conv_layer_sequencer
    import cnn_pkg::*;
#(
    parameter  int N_OUT_CH = 4,
    parameter  int N_IN_CH  = 1,
    parameter  int IMG_W    = 28,
    parameter  int IMG_H    = 28,
    parameter  int K_IDX_W  = (N_OUT_CH * N_IN_CH > 1) ? $clog2(N_OUT_CH * N_IN_CH) : 1,
    localparam int OC_W     = (N_OUT_CH > 1) ? $clog2(N_OUT_CH) : 1,
    localparam int ROW_W    = $clog2(IMG_H),
    localparam int COL_W    = $clog2(IMG_W)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               k_commence_o,
    output logic [K_IDX_W-1:0] k_sel_o,
    input  logic               k_finished_i,
    output logic               win_valid_o,
    input  logic               win_ready_i,
    output logic [ROW_W-1:0]   win_row_o,
    output logic [COL_W-1:0]   win_col_o,
    output logic               acc_first_o,
    output logic               acc_last_o,
    output logic [OC_W-1:0]    oc_o
);

    localparam int IC_W  = (N_IN_CH > 1) ? $clog2(N_IN_CH) : 1;
    localparam int OUT_W = out_w(IMG_W);
    localparam int OUT_H = out_h(IMG_H);

    seq_state_t       state_q, state_d;
    logic [OC_W-1:0]  oc_q;
    logic [IC_W-1:0]  ic_q;
    logic             xfer;
    logic             pos_last;
    logic             ic_wrap;
    logic             oc_wrap;

    assign xfer    = win_valid_o & win_ready_i;
    assign ic_wrap = (ic_q == IC_W'(N_IN_CH - 1));
    assign oc_wrap = (oc_q == OC_W'(N_OUT_CH - 1));

    window_pos_counter #(
        .OUT_W (OUT_W),
        .OUT_H (OUT_H),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_pos (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .advance (xfer),
        .clear   (state_q == S_IDLE),
        .row     (win_row_o),
        .col     (win_col_o),
        .last    (pos_last)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; start and kernel-finished only matter in their own states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start_i) state_d = S_LOAD_REQ;
            S_LOAD_REQ:  state_d = S_LOAD_WAIT;
            S_LOAD_WAIT: if (k_finished_i) state_d = S_STREAM;
            S_STREAM:    if (xfer && pos_last) state_d = S_NEXT;
            S_NEXT:      state_d = (ic_wrap && oc_wrap) ? S_DONE : S_LOAD_REQ;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Channel counters: ic is the inner loop; both wrap to 0 at layer end.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oc_q <= '0;
            ic_q <= '0;
        end else if (state_q == S_IDLE && start_i) begin
            oc_q <= '0;
            ic_q <= '0;
        end else if (state_q == S_NEXT) begin
            if (ic_wrap) begin
                ic_q <= '0;
                oc_q <= oc_wrap ? '0 : oc_q + 1'b1;
            end else begin
                ic_q <= ic_q + 1'b1;
            end
        end
    end

    // Kernel index follows the counters, which only move in NEXT, so it is
    // stable across LOAD_REQ..STREAM.
    assign k_sel_o      = K_IDX_W'(int'(oc_q) * N_IN_CH + int'(ic_q));
    assign oc_o         = oc_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign k_commence_o = (state_q == S_LOAD_REQ);
    assign win_valid_o  = (state_q == S_STREAM);
    assign acc_first_o  = win_valid_o & (ic_q == '0);
    assign acc_last_o   = win_valid_o & ic_wrap;

endmodule
